// File: rtl/rgb2gray_stream.sv
// Purpose : streaming RGB565/RGB888 to 8-bit gray converter. Four modes: weighted, average, max channel, green bypass.
// Latency : 3 cycles from an accepted beat to O_pixel_data_valid when the pipeline is not stalled.
// Backpr. : every stage holds its beat until the next stage frees up, so a beat is never dropped or duplicated.
//           O_ready is low only while all three stages are full and I_out_ready is low (and during reset).
// Ports   : I_clk / I_reset_p            clock, asynchronous active-high reset
//           I_pixel_data_valid/O_ready   input handshake. I_pixel_data_RGB carries the pixel, I_sof/I_eol the sideband.
//           I_mode, I_coef_r/g/b         settings, sampled only on an accepted start-of-frame beat
//           O_pixel_data_valid/I_out_ready  output handshake
//           O_pixel_data_Gray, O_pixel_data_Gray_rgb565, O_sof, O_eol  output beat
module rgb2gray_stream #(
   parameter int IN_FMT = 1,
   parameter int COEF_W = 8,
   parameter int DEF_R  = 76,
   parameter int DEF_G  = 150,
   parameter int DEF_B  = 30
) (
   input  logic              I_clk,
   input  logic              I_reset_p,
   input  logic              I_pixel_data_valid,
   output logic              O_ready,
   input  logic [23:0]       I_pixel_data_RGB,
   input  logic              I_sof,
   input  logic              I_eol,
   input  logic [1:0]        I_mode,
   input  logic [COEF_W-1:0] I_coef_r,
   input  logic [COEF_W-1:0] I_coef_g,
   input  logic [COEF_W-1:0] I_coef_b,
   output logic              O_pixel_data_valid,
   input  logic              I_out_ready,
   output logic [7:0]        O_pixel_data_Gray,
   output logic [15:0]       O_pixel_data_Gray_rgb565,
   output logic              O_sof,
   output logic              O_eol
);

   localparam int PW = 8 + COEF_W;    // one channel*coefficient product
   localparam int SW = 10 + COEF_W;   // sum of three products plus the rounding term
   localparam logic [SW-1:0] HALF = SW'(1) << (COEF_W - 1);

   typedef struct packed {
      logic [7:0]        r;
      logic [7:0]        g;
      logic [7:0]        b;
      logic [1:0]        mode;
      logic [COEF_W-1:0] cr;
      logic [COEF_W-1:0] cg;
      logic [COEF_W-1:0] cb;
      logic              sof;
      logic              eol;
   } s1_t;

   typedef struct packed {
      logic [PW-1:0] pr;
      logic [PW-1:0] pg;
      logic [PW-1:0] pb;
      logic [16:0]   avg_p;   // (R+G+B)*171, at most 130815
      logic [7:0]    alt;     // max channel or green, by mode
      logic [1:0]    mode;
      logic          sof;
      logic          eol;
   } s2_t;

   logic              v1, v2, v3;
   logic              en1, en2, en3;
   logic              accept;
   s1_t               s1_d, s1_q;
   s2_t               s2_d, s2_q;
   logic [7:0]        gray_d, gray_q;
   logic              sof_q, eol_q;
   logic [1:0]        mode_sh;
   logic [COEF_W-1:0] cr_sh, cg_sh, cb_sh;
   logic [SW-1:0]     wsum, wsh;

   // A stage may load when it is empty or when its own content moves on in the same cycle.
   assign en3    = ~v3 | I_out_ready;
   assign en2    = ~v2 | en3;
   assign en1    = ~v1 | en2;
   assign O_ready = en1 & ~I_reset_p;
   assign accept  = I_pixel_data_valid & O_ready;

   // ---------------- S1: unpack and register ----------------
   always_comb begin
      s1_d = '0;
      if (IN_FMT == 0) begin
         // MSB replication keeps full-scale 565 values at 255
         s1_d.r = {I_pixel_data_RGB[15:11], I_pixel_data_RGB[15:13]};
         s1_d.g = {I_pixel_data_RGB[10:5],  I_pixel_data_RGB[10:9]};
         s1_d.b = {I_pixel_data_RGB[4:0],   I_pixel_data_RGB[4:2]};
      end else begin
         s1_d.r = I_pixel_data_RGB[23:16];
         s1_d.g = I_pixel_data_RGB[15:8];
         s1_d.b = I_pixel_data_RGB[7:0];
      end
      // An SOF beat already uses the settings it brings in.
      s1_d.mode = I_sof ? I_mode   : mode_sh;
      s1_d.cr   = I_sof ? I_coef_r : cr_sh;
      s1_d.cg   = I_sof ? I_coef_g : cg_sh;
      s1_d.cb   = I_sof ? I_coef_b : cb_sh;
      s1_d.sof  = I_sof;
      s1_d.eol  = I_eol;
   end

   always_ff @(posedge I_clk or posedge I_reset_p) begin
      if (I_reset_p) begin
         v1      <= 1'b0;
         s1_q    <= '0;
         mode_sh <= 2'd0;
         cr_sh   <= COEF_W'(DEF_R);
         cg_sh   <= COEF_W'(DEF_G);
         cb_sh   <= COEF_W'(DEF_B);
      end else begin
         if (en1) begin
            v1 <= I_pixel_data_valid;
            if (I_pixel_data_valid) s1_q <= s1_d;
         end
         if (accept && I_sof) begin
            mode_sh <= I_mode;
            cr_sh   <= I_coef_r;
            cg_sh   <= I_coef_g;
            cb_sh   <= I_coef_b;
         end
      end
   end

   // ---------------- S2: multiply / select ----------------
   always_comb begin
      s2_d       = '0;
      s2_d.pr    = PW'(s1_q.r) * PW'(s1_q.cr);
      s2_d.pg    = PW'(s1_q.g) * PW'(s1_q.cg);
      s2_d.pb    = PW'(s1_q.b) * PW'(s1_q.cb);
      s2_d.avg_p = 17'(10'(s1_q.r) + 10'(s1_q.g) + 10'(s1_q.b)) * 17'd171;
      if (s1_q.mode == 2'd2) begin
         s2_d.alt = s1_q.r;
         if (s1_q.g > s2_d.alt) s2_d.alt = s1_q.g;
         if (s1_q.b > s2_d.alt) s2_d.alt = s1_q.b;
      end else begin
         s2_d.alt = s1_q.g;
      end
      s2_d.mode = s1_q.mode;
      s2_d.sof  = s1_q.sof;
      s2_d.eol  = s1_q.eol;
   end

   always_ff @(posedge I_clk or posedge I_reset_p) begin
      if (I_reset_p) begin
         v2   <= 1'b0;
         s2_q <= '0;
      end else if (en2) begin
         v2 <= v1;
         if (v1) s2_q <= s2_d;
      end
   end

   // ---------------- S3: sum / round / saturate ----------------
   assign wsum = SW'(s2_q.pr) + SW'(s2_q.pg) + SW'(s2_q.pb) + HALF;
   assign wsh  = wsum >> COEF_W;

   always_comb begin
      gray_d = s2_q.alt;
      case (s2_q.mode)
         2'd0:    gray_d = (wsh > SW'(255)) ? 8'hFF : wsh[7:0];
         2'd1:    gray_d = 8'((s2_q.avg_p + 17'd256) >> 9);
         default: gray_d = s2_q.alt;
      endcase
   end

   always_ff @(posedge I_clk or posedge I_reset_p) begin
      if (I_reset_p) begin
         v3     <= 1'b0;
         gray_q <= 8'd0;
         sof_q  <= 1'b0;
         eol_q  <= 1'b0;
      end else if (en3) begin
         v3 <= v2;
         if (v2) begin
            gray_q <= gray_d;
            sof_q  <= s2_q.sof;
            eol_q  <= s2_q.eol;
         end
      end
   end

   assign O_pixel_data_valid       = v3;
   assign O_pixel_data_Gray        = gray_q;
   assign O_pixel_data_Gray_rgb565 = {gray_q[7:3], gray_q[7:2], gray_q[7:3]};
   assign O_sof                    = sof_q;
   assign O_eol                    = eol_q;

endmodule
